// File: rtl/pll_lock_sequencer.sv
// Turns the raw asynchronous PLL lock flag into a filtered, synchronously released reset and ready flag
// for pixel-clock logic, and counts lock losses seen while running.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  locked,
  input  logic                  clear_count,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  loss_pulse,
  output logic [LOSS_CNT_W-1:0] loss_count,
  output logic [1:0]            state_dbg
);

  localparam int STABLE_W = $clog2(STABLE_CYCLES + 1);
  localparam int HOLD_W   = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [STABLE_W-1:0]   STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
  localparam logic [HOLD_W-1:0]     HOLD_LAST   = HOLD_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);
  localparam logic [LOSS_CNT_W-1:0] LOSS_MAX    = '1;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                  r_state;
  logic [SYNC_STAGES-1:0]  r_sync;
  logic [STABLE_W-1:0]     r_stableCnt;
  logic [HOLD_W-1:0]       r_holdCnt;
  logic                    r_rstOutN;
  logic                    r_ready;
  logic                    r_lossPulse;
  logic [LOSS_CNT_W-1:0]   r_lossCount;
  logic                    w_lkS;

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked};
    end
  end

  assign w_lkS = r_sync[SYNC_STAGES-1];

  // The cycle that moves WAIT_LOCK to STABILIZE counts as the first stable cycle.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= WAIT_LOCK;
      r_stableCnt <= '0;
      r_holdCnt   <= '0;
      r_rstOutN   <= 1'b0;
      r_ready     <= 1'b0;
      r_lossPulse <= 1'b0;
    end else begin
      r_lossPulse <= 1'b0;
      case (r_state)
        WAIT_LOCK: begin
          if (w_lkS) begin
            r_state     <= STABILIZE;
            r_stableCnt <= STABLE_W'(1);
          end
        end
        STABILIZE: begin
          if (!w_lkS) begin
            r_state     <= WAIT_LOCK;
            r_stableCnt <= '0;
          end else if (r_stableCnt >= STABLE_LAST) begin
            r_stableCnt <= '0;
            r_holdCnt   <= '0;
            if (HOLD_CYCLES == 0) begin
              r_state   <= RUN;
              r_rstOutN <= 1'b1;
              r_ready   <= 1'b1;
            end else begin
              r_state   <= HOLD;
            end
          end else begin
            r_stableCnt <= r_stableCnt + STABLE_W'(1);
          end
        end
        HOLD: begin
          if (!w_lkS) begin
            r_state   <= WAIT_LOCK;
            r_holdCnt <= '0;
          end else if (r_holdCnt >= HOLD_LAST) begin
            r_state   <= RUN;
            r_holdCnt <= '0;
            r_rstOutN <= 1'b1;
            r_ready   <= 1'b1;
          end else begin
            r_holdCnt <= r_holdCnt + HOLD_W'(1);
          end
        end
        RUN: begin
          if (!w_lkS) begin
            r_state     <= WAIT_LOCK;
            r_rstOutN   <= 1'b0;
            r_ready     <= 1'b0;
            r_lossPulse <= 1'b1;
          end
        end
        default: begin
          r_state   <= WAIT_LOCK;
          r_rstOutN <= 1'b0;
          r_ready   <= 1'b0;
        end
      endcase
    end
  end

  // Clear has priority over a loss pulse in the same cycle.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_lossCount <= '0;
    end else if (clear_count) begin
      r_lossCount <= '0;
    end else if (r_lossPulse && (r_lossCount != LOSS_MAX)) begin
      r_lossCount <= r_lossCount + LOSS_CNT_W'(1);
    end
  end

  assign rst_out_n  = r_rstOutN;
  assign ready      = r_ready;
  assign loss_pulse = r_lossPulse;
  assign loss_count = r_lossCount;
  assign state_dbg  = r_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench: a default sequencer and a fast one (STABLE 4, HOLD 0, 2-bit loss counter),
// with expected values queued at stimulus time and popped when the DUT output is sampled.
module tb_pll_lock_sequencer;

  localparam int SYNC    = 2;
  localparam int STABLE0 = 1024;
  localparam int HOLD0   = 16;
  localparam int STABLE1 = 4;
  localparam int HOLD1   = 0;
  localparam int LAT0    = SYNC + STABLE0 + HOLD0;
  localparam int LAT1    = SYNC + STABLE1 + HOLD1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic locked0 = 1'b0, clear0 = 1'b0, locked1 = 1'b0, clear1 = 1'b0;
  logic rstOut0, ready0, pulse0, rstOut1, ready1, pulse1;
  logic [7:0] lossCnt0;
  logic [1:0] lossCnt1, state0, state1;

  int checkCount = 0;
  int errorCount = 0;
  int pulseCnt0 = 0;
  int pulseCnt1 = 0;
  logic sawHold1 = 1'b0;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  pll_lock_sequencer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE0), .HOLD_CYCLES(HOLD0), .LOSS_CNT_W(8)) dut0 (
    .clock_in(clk), .reset_n(reset_n), .locked(locked0), .clear_count(clear0),
    .rst_out_n(rstOut0), .ready(ready0), .loss_pulse(pulse0), .loss_count(lossCnt0), .state_dbg(state0));

  pll_lock_sequencer #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE1), .HOLD_CYCLES(HOLD1), .LOSS_CNT_W(2)) dut1 (
    .clock_in(clk), .reset_n(reset_n), .locked(locked1), .clear_count(clear1),
    .rst_out_n(rstOut1), .ready(ready1), .loss_pulse(pulse1), .loss_count(lossCnt1), .state_dbg(state1));

  always @(negedge clk) begin
    if (pulse0 === 1'b1) pulseCnt0++;
    if (pulse1 === 1'b1) pulseCnt1++;
    if (state1 === 2'd2) sawHold1 = 1'b1;
  end

  task automatic pushExpected(input string tag, input logic [31:0] value);
    exp_t e;
    e.tag = tag;
    e.value = value;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input logic [31:0] observed);
    exp_t e;
    checkCount++;
    if (expQ.size() == 0) begin
      errorCount++;
      $error("[TB] FAIL scoreboard: observed %0d with no queued expectation", observed);
    end else begin
      e = expQ.pop_front();
      assert (observed === e.value) else begin
        errorCount++;
        $error("[TB] FAIL %s: observed %0d expected %0d", e.tag, observed, e.value);
      end
    end
  endtask

  task automatic applyStimulus(input int dutSel, input logic lockVal, input logic clearVal);
    if (dutSel == 0) begin
      locked0 = lockVal;
      clear0  = clearVal;
    end else begin
      locked1 = lockVal;
      clear1  = clearVal;
    end
  endtask

  task automatic waitCycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Counts rising edges until ready is seen high, giving up at the budget.
  task automatic waitReady(input int dutSel, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if ((dutSel == 0 ? ready0 : ready1) === 1'b1) break;
    end
  endtask

  function automatic int withinOne(input int n, input int target);
    return (n >= target - 1 && n <= target + 1) ? target : n;
  endfunction

  initial begin
    int n;
    logic found;

    $display("[TB] start");
    waitCycles(3);
    pushExpected("resetRstOut", 0);   checkOutput(rstOut0);
    pushExpected("resetReady", 0);    checkOutput(ready0);
    pushExpected("resetPulse", 0);    checkOutput(pulse0);
    pushExpected("resetLossCnt", 0);  checkOutput(lossCnt0);
    pushExpected("resetState", 0);    checkOutput(state0);
    reset_n = 1'b1;

    // Lock acquisition.
    waitCycles(10);
    applyStimulus(0, 1'b1, 1'b0);
    pushExpected("lockLatency", LAT0);
    waitReady(0, 3000, n);
    checkOutput(withinOne(n, LAT0));
    pushExpected("lockRstOut", 1);    checkOutput(rstOut0);
    pushExpected("lockState", 3);     checkOutput(state0);
    pushExpected("lockPulses", 0);    checkOutput(pulseCnt0);
    pushExpected("lockLossCnt", 0);   checkOutput(lossCnt0);

    // Loss in RUN and relock.
    applyStimulus(0, 1'b0, 1'b0);
    pushExpected("lossLatency", SYNC + 1);
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rstOut0 === 1'b0) break;
    end
    checkOutput((n >= 1 && n <= SYNC + 1) ? SYNC + 1 : n);
    pushExpected("lossReady", 0);     checkOutput(ready0);
    waitCycles(3);
    pushExpected("lossPulses", 1);    checkOutput(pulseCnt0);
    pushExpected("lossCount1", 1);    checkOutput(lossCnt0);
    applyStimulus(0, 1'b1, 1'b0);
    pushExpected("relockLatency", LAT0);
    waitReady(0, 3000, n);
    checkOutput(withinOne(n, LAT0));

    // Asynchronous reset in the middle of HOLD.
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(5);
    pushExpected("lossCount2", 2);    checkOutput(lossCnt0);
    applyStimulus(0, 1'b1, 1'b0);
    n = 0;
    while (n < 1200 && state0 !== 2'd2) begin
      @(negedge clk);
      n++;
    end
    pushExpected("reachHold", 2);     checkOutput(state0);
    waitCycles(5);
    #2 reset_n = 1'b0;
    #1;
    pushExpected("asyncRstOut", 0);   checkOutput(rstOut0);
    pushExpected("asyncState", 0);    checkOutput(state0);
    pushExpected("asyncLossCnt", 0);  checkOutput(lossCnt0);
    pushExpected("asyncPulse", 0);    checkOutput(pulse0);
    @(negedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    pushExpected("asyncPulses", 2);   checkOutput(pulseCnt0);
    waitCycles(2);
    reset_n = 1'b1;

    // Glitch while stabilizing.
    waitCycles(10);
    applyStimulus(0, 1'b1, 1'b0);
    waitCycles(500);
    applyStimulus(0, 1'b0, 1'b0);
    waitCycles(3);
    pushExpected("glitchState", 0);   checkOutput(state0);
    applyStimulus(0, 1'b1, 1'b0);
    pushExpected("glitchLatency", LAT0);
    waitReady(0, 3000, n);
    checkOutput(withinOne(n, LAT0));
    pushExpected("glitchLossCnt", 0); checkOutput(lossCnt0);
    pushExpected("glitchPulses", 2);  checkOutput(pulseCnt0);

    // Fast instance: no HOLD phase.
    applyStimulus(1, 1'b1, 1'b0);
    pushExpected("fastLatency", LAT1);
    waitReady(1, 50, n);
    checkOutput(withinOne(n, LAT1));
    pushExpected("fastState", 3);     checkOutput(state1);
    pushExpected("fastNoHold", 0);    checkOutput(sawHold1);

    // Saturation of the 2-bit loss counter.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1'b0, 1'b0);
      waitCycles(4);
      applyStimulus(1, 1'b1, 1'b0);
      waitCycles(8);
      pushExpected("satCount", (i + 1 > 3) ? 3 : i + 1);
      checkOutput(lossCnt1);
    end
    pushExpected("satPulses", 5);     checkOutput(pulseCnt1);

    // Clear on the same cycle as a sixth loss.
    applyStimulus(1, 1'b0, 1'b0);
    found = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (pulse1 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    applyStimulus(1, 1'b0, 1'b1);
    pushExpected("sixthPulseSeen", 1); checkOutput(found);
    @(negedge clk);
    applyStimulus(1, 1'b0, 1'b0);
    pushExpected("clearWins", 0);     checkOutput(lossCnt1);
    waitCycles(3);
    pushExpected("clearHolds", 0);    checkOutput(lossCnt1);
    pushExpected("clearPulses", 6);   checkOutput(pulseCnt1);
    pushExpected("fastNoHoldEnd", 0); checkOutput(sawHold1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Consumer end of the PLL lock interface. Runs on the PLL output clock (e.g. the 272 MHz pixel-side clock).
- Takes the raw asynchronous `locked` flag and produces a clean, glitch-filtered, synchronously deasserted active-low reset and a ready flag for downstream VGA timing logic.
- Also reports lock-loss events with a pulse and a saturating counter.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the `locked` synchronizer; legal values 2 to 4.
- STABLE_CYCLES, 1024, consecutive synchronized-high cycles of `locked` required before lock is accepted.
- HOLD_CYCLES, 16, cycles `rst_out_n` stays low after lock is accepted.
- LOSS_CNT_W, 8, width of the lock-loss counter.

Ports:
- clock_in  input  1  PLL output clock; the only clock.
- reset_n  input  1  asynchronous active-low reset.
- locked  input  1  raw PLL lock flag, asynchronous to clock_in.
- clear_count  input  1  synchronous clear of loss_count, level-sensitive.
- rst_out_n  output  1  downstream active-low reset; asserts asynchronously, deasserts synchronously.
- ready  output  1  high only in RUN.
- loss_pulse  output  1  one-cycle pulse on each lock loss seen in RUN.
- loss_count  output  LOSS_CNT_W  saturating count of lock losses.
- state_dbg  output  2  current state encoding.

Behaviour:
- Reset (reset_n low, asynchronous):
  - synchronizer chain = 0, state = WAIT_LOCK, counters = 0.
  - rst_out_n = 0 immediately, with no clock required.
  - ready = 0, loss_pulse = 0, loss_count = 0.
- Synchronizer: `locked` passes through SYNC_STAGES flops to give lk_s. All decisions use lk_s only.
- State encoding: WAIT_LOCK = 0, STABILIZE = 1, HOLD = 2, RUN = 3.
- WAIT_LOCK: rst_out_n = 0, ready = 0. If lk_s = 1, go to STABILIZE with stable_cnt = 1.
- STABILIZE:
  - lk_s = 1: stable_cnt increments.
  - When stable_cnt reaches STABLE_CYCLES with lk_s still high, go to HOLD with hold_cnt = 0.
  - lk_s = 0 on any cycle: return to WAIT_LOCK and clear stable_cnt. This is the glitch filter; no loss is counted.
- HOLD:
  - rst_out_n = 0, ready = 0, hold_cnt increments each cycle.
  - After exactly HOLD_CYCLES cycles in HOLD, go to RUN.
  - lk_s = 0 in HOLD: go to WAIT_LOCK; no loss is counted.
- RUN:
  - rst_out_n = 1, ready = 1. Both are registered outputs that rise on the same edge the state becomes RUN.
  - lk_s = 0: next state WAIT_LOCK. rst_out_n and ready drop on that edge, and loss_pulse = 1 for that one cycle.
- Latency: from `locked` rising (asserted continuously) to rst_out_n rising = SYNC_STAGES + STABLE_CYCLES + HOLD_CYCLES cycles, ±1 for synchronizer sampling. Defaults: 1042 ±1.
- loss_count:
  - increments on each loss_pulse and saturates at 2^LOSS_CNT_W − 1 (no wrap).
  - clear_count = 1 forces it to 0 next edge.
  - If clear_count and loss_pulse occur on the same cycle, clear wins: count = 0.
- Counters:
  - stable_cnt width = clog2(STABLE_CYCLES + 1); hold_cnt width = clog2(HOLD_CYCLES + 1).
  - Neither counter advances outside its own state.
  - HOLD_CYCLES = 0 is legal: STABILIZE goes directly to RUN.
- Reset mid-operation: reset_n low in any state forces rst_out_n low asynchronously and restarts the sequence. loss_count is cleared; a reset is not counted as a loss.
- `locked` toggling faster than SYNC_STAGES cycles: behaviour is defined only by the lk_s sequence. No metastability-driven double transitions are allowed.

Test Plan:
- Lock acquisition: release reset_n, raise `locked` at cycle 10 and hold it, defaults → rst_out_n and ready rise at cycle 1052 ±1; loss_pulse never fires; loss_count = 0.
- Glitch during stabilize: `locked` high for 500 cycles, low for 3, then high → state returns to WAIT_LOCK; rst_out_n rises only 1042 ±1 cycles after the second rise; loss_count = 0.
- Loss in RUN: reach RUN, drop `locked` → within SYNC_STAGES+1 cycles rst_out_n = 0 and ready = 0; exactly one loss_pulse; loss_count = 1; relock → RUN again after 1042 ±1 cycles.
- Saturation and clear: LOSS_CNT_W = 2, force 5 losses → loss_count sticks at 3. Assert clear_count on the same cycle as a sixth loss → loss_count = 0.
- Async reset in HOLD: assert reset_n low mid-HOLD with no clock edge → rst_out_n = 0 and state_dbg = 0 immediately; loss_count = 0; no loss_pulse.
- HOLD_CYCLES = 0, STABLE_CYCLES = 4: steady `locked` → ready rises SYNC_STAGES + 4 ±1 cycles after `locked`; state_dbg never shows 2.
